// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch queue.
package fetch_pkg;

  typedef struct packed {
    logic [31:0] inst;
    logic [31:0] pc;
  } fetch_entry_t;

  localparam logic [31:0] NOP_INST = 32'h0;
  localparam int unsigned FQ_DEPTH_DEFAULT = 4;

endpackage

// File: rtl/fetch_queue.sv
// Instruction fetch queue: circular FIFO of {inst, pc} between imem and decode.
// Optional same-cycle bypass of an empty queue when FQ_BYPASS_EN is defined.
module fetch_queue
  import fetch_pkg::*;
#(
  parameter int unsigned DEPTH = FQ_DEPTH_DEFAULT,
  localparam int unsigned CW = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [31:0]   inst_in,
  input  logic          inst_in_valid,
  input  logic [31:0]   pc_in,
  input  logic          flush,
  input  logic          deq_ready,
  output logic [31:0]   inst_out,
  output logic [31:0]   pc_out,
  output logic          inst_out_valid,
  output logic          fetch_stall,
  output logic [CW-1:0] count,
  output logic          overflow
);

  localparam int unsigned AW = $clog2(DEPTH);

  fetch_entry_t          mem_q [DEPTH];
  fetch_entry_t          mem_d [DEPTH];
  logic [AW-1:0]         wp_q, wp_d;
  logic [AW-1:0]         rp_q, rp_d;
  logic [CW-1:0]         count_q, count_d;
  logic                  overflow_q, overflow_d;

  logic                  stored_valid;
  logic                  full;
  logic                  bypass;
  logic                  enq;
  logic                  deq;
  fetch_entry_t          head;
  fetch_entry_t          in_entry;

  assign stored_valid = (count_q != '0);
  assign full         = (count_q == CW'(DEPTH));
  assign in_entry     = '{inst: inst_in, pc: pc_in};
  assign head         = mem_q[rp_q];

`ifdef FQ_BYPASS_EN
  assign bypass = !stored_valid && inst_in_valid && !flush;
`else
  assign bypass = 1'b0;
`endif

  // A bypassed word consumed by decode in the same cycle is never stored.
  assign enq = inst_in_valid && !flush && !full && !(bypass && deq_ready);
  assign deq = stored_valid && deq_ready && !flush;

  always_comb begin
    mem_d      = mem_q;
    wp_d       = wp_q;
    rp_d       = rp_q;
    count_d    = count_q;
    overflow_d = overflow_q;
    if (flush) begin
      wp_d    = '0;
      rp_d    = '0;
      count_d = '0;
    end else begin
      if (enq) begin
        mem_d[wp_q] = in_entry;
        wp_d        = wp_q + AW'(1);
      end
      if (deq) begin
        rp_d = rp_q + AW'(1);
      end
      if (enq && !deq) begin
        count_d = count_q + CW'(1);
      end else if (deq && !enq) begin
        count_d = count_q - CW'(1);
      end
      if (inst_in_valid && full) begin
        overflow_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem_q[i] <= '0;
      end
      wp_q       <= '0;
      rp_q       <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      mem_q      <= mem_d;
      wp_q       <= wp_d;
      rp_q       <= rp_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
    end
  end

  // Head presentation and stall are combinational from registered state.
  assign inst_out_valid = (stored_valid || bypass) && !flush;
  assign inst_out       = !inst_out_valid ? NOP_INST :
                          (stored_valid ? head.inst : inst_in);
  assign pc_out         = !inst_out_valid ? 32'h0 :
                          (stored_valid ? head.pc : pc_in);
  assign fetch_stall    = (count_q >= CW'(DEPTH - 1)) && !flush;
  assign count          = count_q;
  assign overflow       = overflow_q;

endmodule

// File: tb/tb_fetch_queue.sv
// Directed self-checking bench for fetch_queue (default DEPTH=4).
`timescale 1ns/1ps
module tb_fetch_queue;

  logic        clk;
  logic        rst;
  logic [31:0] inst_in;
  logic        inst_in_valid;
  logic [31:0] pc_in;
  logic        flush;
  logic        deq_ready;
  logic [31:0] inst_out;
  logic [31:0] pc_out;
  logic        inst_out_valid;
  logic        fetch_stall;
  logic [2:0]  count;
  logic        overflow;

  int n_checks = 0;
  int n_errors = 0;

  fetch_queue dut (
    .clk            (clk),
    .rst            (rst),
    .inst_in        (inst_in),
    .inst_in_valid  (inst_in_valid),
    .pc_in          (pc_in),
    .flush          (flush),
    .deq_ready      (deq_ready),
    .inst_out       (inst_out),
    .pc_out         (pc_out),
    .inst_out_valid (inst_out_valid),
    .fetch_stall    (fetch_stall),
    .count          (count),
    .overflow       (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] inst, input logic [31:0] pc,
                       input logic dr, input logic fl);
    inst_in_valid = v;
    inst_in       = inst;
    pc_in         = pc;
    deq_ready     = dr;
    flush         = fl;
  endtask

  initial begin
    rst = 1'b0;
    drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    #3;
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_valid", 32'(inst_out_valid), 32'd0);
    chk("rst_stall", 32'(fetch_stall), 32'd0);
    chk("rst_ovf", 32'(overflow), 32'd0);
    chk("rst_inst", inst_out, 32'h0);
    #4 rst = 1'b1;
    tick();

    // Fill 0x11..0x44 with decode stalled.
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 32'(32'h11 * (i + 1)), 32'(4 * i), 1'b0, 1'b0);
      #2;
      chk($sformatf("fill_count%0d", i), 32'(count), 32'(i));
      chk($sformatf("fill_stall%0d", i), 32'(fetch_stall), (i >= 3) ? 32'd1 : 32'd0);
      tick();
    end
    drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    #2;
    chk("full_count", 32'(count), 32'd4);
    chk("full_stall", 32'(fetch_stall), 32'd1);
    chk("full_ovf", 32'(overflow), 32'd0);
    chk("full_head", inst_out, 32'h11);

    // Drain one per cycle.
    deq_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk($sformatf("drain_inst%0d", i), inst_out, 32'(32'h11 * (i + 1)));
      chk($sformatf("drain_pc%0d", i), pc_out, 32'(4 * i));
      chk($sformatf("drain_valid%0d", i), 32'(inst_out_valid), 32'd1);
      chk($sformatf("drain_stall%0d", i), 32'(fetch_stall), ((4 - i) >= 3) ? 32'd1 : 32'd0);
      tick();
    end
    #1;
    chk("empty_valid", 32'(inst_out_valid), 32'd0);
    chk("empty_inst", inst_out, 32'h0);
    chk("empty_count", 32'(count), 32'd0);
    chk("empty_stall", 32'(fetch_stall), 32'd0);

    // Streaming with decode always ready.
    for (int i = 0; i < 6; i++) begin
      drive(1'b1, 32'(32'h100 + i), 32'(32'h40 + 4 * i), 1'b1, 1'b0);
      #2;
`ifdef FQ_BYPASS_EN
      chk($sformatf("stream_inst%0d", i), inst_out, 32'(32'h100 + i));
      chk($sformatf("stream_count%0d", i), 32'(count), 32'd0);
`else
      if (i > 0) begin
        chk($sformatf("stream_inst%0d", i), inst_out, 32'(32'h100 + i - 1));
        chk($sformatf("stream_pc%0d", i), pc_out, 32'(32'h40 + 4 * (i - 1)));
        chk($sformatf("stream_count%0d", i), 32'(count), 32'd1);
      end else begin
        chk("stream_first_valid", 32'(inst_out_valid), 32'd0);
      end
`endif
      tick();
    end
    drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    tick();
    tick();
    chk("stream_end_count", 32'(count), 32'd0);

    // Flush with three entries while a new word arrives.
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 32'(32'hA1 + i), 32'(32'h80 + 4 * i), 1'b0, 1'b0);
      tick();
    end
    chk("preflush_count", 32'(count), 32'd3);
    drive(1'b1, 32'hDEAD, 32'h90, 1'b0, 1'b1);
    #2;
    chk("flush_cyc_valid", 32'(inst_out_valid), 32'd0);
    chk("flush_cyc_stall", 32'(fetch_stall), 32'd0);
    tick();
    drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    #1;
    chk("postflush_count", 32'(count), 32'd0);
    chk("postflush_valid", 32'(inst_out_valid), 32'd0);
    chk("postflush_stall", 32'(fetch_stall), 32'd0);
    drive(1'b1, 32'hB1, 32'hC0, 1'b0, 1'b0);
    tick();
    drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    #1;
    chk("postflush_head", inst_out, 32'hB1);
    chk("postflush_pc", pc_out, 32'hC0);
    chk("postflush_count1", 32'(count), 32'd1);
    deq_ready = 1'b1;
    tick();
    deq_ready = 1'b0;
    #1;
    chk("postflush_drain", 32'(count), 32'd0);

    // Forced overflow ignoring fetch_stall.
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 32'(32'h11 * (i + 1)), 32'(4 * i), 1'b0, 1'b0);
      tick();
    end
    drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    #1;
    chk("ovf_set", 32'(overflow), 32'd1);
    chk("ovf_count", 32'(count), 32'd4);
    chk("ovf_head", inst_out, 32'h11);
    tick();
    tick();
    chk("ovf_sticky", 32'(overflow), 32'd1);

    // Async reset between edges.
    #2 rst = 1'b0;
    #1;
    chk("arst_count", 32'(count), 32'd0);
    chk("arst_valid", 32'(inst_out_valid), 32'd0);
    chk("arst_inst", inst_out, 32'h0);
    chk("arst_stall", 32'(fetch_stall), 32'd0);
    chk("arst_ovf", 32'(overflow), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    tick();
    chk("post_rst_count", 32'(count), 32'd0);
    chk("post_rst_valid", 32'(inst_out_valid), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  // Hard time bound so the bench always terminates.
  initial begin
    #20000;
    $display("FAIL timeout: bench did not complete");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/fetch_queue.md
# fetch_queue

Instruction fetch queue between the instruction memory and the decode stage. It captures each valid fetched word with its PC into a small circular FIFO and presents the oldest entry to decode through a valid/ready handshake. It generates the fetch stall that throttles the instruction memory and PC logic, and it discards all buffered instructions on a branch mispredict.

## Interface
- DEPTH, 4: number of queue entries; power of two, minimum 2.
- CW, $clog2(DEPTH)+1: width of the occupancy count (derived, not overridden).
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-low reset.
- inst_in  input  32  instruction word from instruction memory (registered there).
- inst_in_valid  input  1  inst_in carries a real instruction this cycle.
- pc_in  input  32  PC of inst_in, aligned with inst_in by the fetch logic.
- flush  input  1  mispredict; empties the queue this cycle.
- deq_ready  input  1  decode accepts the head entry this cycle.
- inst_out  output  32  head instruction; 32'h0 when inst_out_valid is low.
- pc_out  output  32  head PC; 32'h0 when inst_out_valid is low.
- inst_out_valid  output  1  head entry valid.
- fetch_stall  output  1  to instruction-memory stall and PC hold.
- count  output  CW  current occupancy, 0..DEPTH.
- overflow  output  1  sticky error: enqueue attempted while full.

## Operation
- State: storage array of {inst, pc}, write pointer wp, read pointer rp (log2 DEPTH bits each, natural wrap), registered count.
- Enqueue: inst_in_valid && !flush && (count < DEPTH); the entry is written at wp, and wp increments.
- Dequeue: inst_out_valid && deq_ready && !flush; rp increments.
- Simultaneous enqueue and dequeue: count is unchanged. When full, a same-cycle dequeue does not make room for an enqueue; the full check uses the registered count.
- Enqueue while count == DEPTH: the data is dropped, overflow is set and holds until reset. This case is unreachable when fetch_stall is honoured.
- inst_out, pc_out and inst_out_valid are combinational from the head entry: valid = (count != 0) && !flush.
- Flush has priority over everything. count, wp and rp go to 0 at the edge, inst_in is dropped, and inst_out_valid is forced low during the flush cycle.
- fetch_stall = (count >= DEPTH-1), taken from the registered count. One slot is reserved for the instruction already in flight from the one-cycle-latency memory.
- fetch_stall is forced low during flush so fetch restarts at the redirected PC immediately.
- Reset: all outputs 0, pointers 0, count 0, overflow 0. Reset asserted mid-operation discards contents identically to a flush and also clears overflow.

## Timing
- Enqueue to visible at inst_out: 1 cycle, with the entry written at edge N and valid in cycle N+1. This is 0 cycles with bypass (see Configuration).
- Dequeue takes effect at the edge, and the next entry is presented in the following cycle.
- Throughput: one instruction per cycle sustained when deq_ready is held high.
- fetch_stall rises in the cycle after count reaches DEPTH-1. It falls in the cycle after a dequeue brings count below DEPTH-1.
- Flush in cycle N: the queue is empty and inst_out_valid is 0 in cycle N+1.

## Configuration
- FQ_BYPASS_EN defined: when count == 0 and inst_in_valid && !flush, inst_in/pc_in drive the outputs combinationally in the same cycle with inst_out_valid high.
  - If deq_ready is also high, nothing is written and count stays 0.
  - If deq_ready is low, the entry is written normally.
- FQ_BYPASS_EN undefined: outputs come only from storage, with a fixed 1-cycle minimum latency. All other behaviour is identical.

## Structure
- Shared package fetch_pkg holds:
  - typedef fetch_entry_t, a packed struct {logic [31:0] inst; logic [31:0] pc}.
  - localparam NOP_INST = 32'h0.
  - FQ_DEPTH_DEFAULT = 4.
- No sub-module: storage, pointers and count fit in one module.

## Test plan
- Reset, then fill: 4 back-to-back valid words 0x11..0x44 with pc 0x0..0xC and deq_ready=0 -> count reaches 4. fetch_stall rises after the third, and overflow stays 0.
- Drain: deq_ready=1 from full -> inst_out shows 0x11, 0x22, 0x33, 0x44 on consecutive cycles with matching PCs, then inst_out_valid=0 and fetch_stall=0 when count <= 2.
- Streaming: continuous valid input with deq_ready=1 -> one instruction per cycle out, count constant (0 with bypass, 1 without).
- Flush with count=3 while inst_in_valid=1 -> the next cycle has count=0, inst_out_valid=0 and fetch_stall=0. The flush-cycle input never appears.
- Forced overflow: drive inst_in_valid ignoring fetch_stall at count=4 -> overflow=1 and sticky, head still 0x11, count stays 4. Reset clears it.
- Async reset asserted mid-stream between clock edges -> all outputs 0 immediately, and the queue is empty after release.
